mips_run_controller: RTL and testbench

Parametrised program-memory and run-control block for the single-cycle MIPS core. It holds the program in a byte-addressed instruction store filled through a valid/ready word-load port. It then releases the core from reset and serves fetches. During the run it counts consecutive NOP fetches, enforces a cycle timeout and folds ALU results into a 32-bit signature, so benches and FPGA top levels get a deterministic halt and pass/fail status.

---
 rtl/mips_run_controller.sv | 147 ++++++++++++++
 tb/tb_mips_run_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_controller.sv
// Program store and run control for the single-cycle MIPS core: loads the program,
// releases the core, serves fetches and reports a deterministic halt, timeout and signature.
module mips_run_controller #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned NOP_LIMIT   = 3,
    parameter int unsigned MAX_CYCLES  = 1024,
    parameter logic [31:0] SIG_SEED    = 32'h0,
    localparam int unsigned WA_W       = $clog2(DEPTH_BYTES / 4)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [WA_W:0]   load_addr,
    input  logic [31:0]     load_data,
    input  logic            load_last,
    output logic            cpu_reset,
    input  logic [31:0]     fetch_pc,
    output logic [31:0]     fetch_instr,
    input  logic [31:0]     alu_result,
    output logic            halted,
    output logic            timed_out,
    output logic            load_err,
    output logic [31:0]     cycle_count,
    output logic [31:0]     signature
);

    localparam int unsigned BA_W = WA_W + 2;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [7:0]  mem_d [DEPTH_BYTES];
    logic        load_err_q, load_err_d;
    logic        halted_q, halted_d;
    logic        timed_out_q, timed_out_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] signature_q, signature_d;
    logic [7:0]  nop_run_q, nop_run_d;
    logic        is_nop;
    logic        handshake;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^fetch_pc[1:0];

    // Fetch ignores the two low PC bits and reads zero beyond the store.
    always_comb begin
        fetch_instr = 32'h0;
        if (fetch_pc < 32'(DEPTH_BYTES)) begin
            for (int b = 0; b < 4; b++) begin
                fetch_instr[8*b +: 8] = mem_q[{fetch_pc[BA_W-1:2], 2'(b)}];
            end
        end
    end

    assign is_nop     = (fetch_instr == 32'h0);
    assign load_ready = (state_q == ST_LOAD);
    assign cpu_reset  = (state_q != ST_RUN);
    assign handshake  = load_valid && load_ready;

    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        load_err_d    = load_err_q;
        halted_d      = halted_q;
        timed_out_d   = timed_out_q;
        cycle_count_d = cycle_count_q;
        signature_d   = signature_q;
        nop_run_d     = nop_run_q;

        case (state_q)
            ST_LOAD: begin
                if (handshake) begin
                    if (load_addr[WA_W]) begin
                        load_err_d = 1'b1;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            mem_d[{load_addr[WA_W-1:0], 2'(b)}] = load_data[8*b +: 8];
                        end
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                signature_d   = {signature_q[30:0], signature_q[31]} ^ alu_result;
                if (is_nop) begin
                    nop_run_d = (nop_run_q == 8'hFF) ? 8'hFF : nop_run_q + 8'd1;
                end else begin
                    nop_run_d = 8'h0;
                end
                // A halt on the final permitted cycle takes priority over the timeout.
                if (is_nop && (nop_run_d == 8'(NOP_LIMIT))) begin
                    halted_d = 1'b1;
                    state_d  = ST_DONE;
                end else if (cycle_count_q == 32'(MAX_CYCLES - 1)) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            load_err_q    <= 1'b0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= 32'h0;
            signature_q   <= SIG_SEED;
            nop_run_q     <= 8'h0;
        end else begin
            state_q       <= state_d;
            load_err_q    <= load_err_d;
            halted_q      <= halted_d;
            timed_out_q   <= timed_out_d;
            cycle_count_q <= cycle_count_d;
            signature_q   <= signature_d;
            nop_run_q     <= nop_run_d;
        end
    end

    // NOTE: the store is deliberately reset so a discarded program fetches as all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: 8'h00};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign load_err    = load_err_q;
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;
    assign signature   = signature_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Self-checking bench for mips_run_controller: directed scenarios plus randomized
// load/run sequences compared against a behavioural model.
module tb_mips_run_controller;

    localparam int          DEPTH = 256;
    localparam int          NOPL  = 3;
    localparam int          MAXC  = 16;
    localparam logic [31:0] SEED  = 32'h0;
    localparam int          WA_W  = $clog2(DEPTH / 4);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic [WA_W:0]   load_addr = '0;
    logic [31:0]     load_data = '0;
    logic            load_last = 1'b0;
    logic            cpu_reset;
    logic [31:0]     fetch_pc = '0;
    logic [31:0]     fetch_instr;
    logic [31:0]     alu_result = '0;
    logic            halted;
    logic            timed_out;
    logic            load_err;
    logic [31:0]     cycle_count;
    logic [31:0]     signature;

    always #5 clk = ~clk;

    mips_run_controller #(
        .DEPTH_BYTES(DEPTH), .NOP_LIMIT(NOPL), .MAX_CYCLES(MAXC), .SIG_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last),
        .cpu_reset(cpu_reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .alu_result(alu_result), .halted(halted), .timed_out(timed_out),
        .load_err(load_err), .cycle_count(cycle_count), .signature(signature)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: a byte array plus "loading / running / finished" flags.
    logic [7:0]  m_mem [DEPTH];
    bit          m_valid = 0;
    bit          m_run, m_done, m_halted, m_to, m_err;
    int unsigned m_cycles, m_nop;
    logic [31:0] m_sig;

    function automatic logic [31:0] m_fetch(input logic [31:0] pc);
        int unsigned p;
        if (pc >= DEPTH) return 32'h0;
        p = pc - (pc % 4);
        return {m_mem[p+3], m_mem[p+2], m_mem[p+1], m_mem[p]};
    endfunction

    task automatic model_step();
        logic [31:0] instr;
        int unsigned old;
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_run = 0; m_done = 0; m_halted = 0; m_to = 0; m_err = 0;
            m_cycles = 0; m_nop = 0; m_sig = SEED; m_valid = 1;
        end else if (!m_run && !m_done) begin
            if (load_valid) begin
                if (int'(load_addr) >= DEPTH / 4) m_err = 1;
                else for (int b = 0; b < 4; b++)
                    m_mem[int'(load_addr) * 4 + b] = 8'(load_data >> (8 * b));
                if (load_last) m_run = 1;
            end
        end else if (m_run) begin
            instr = m_fetch(fetch_pc);
            old = m_cycles;
            m_cycles = m_cycles + 1;
            m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ alu_result;
            m_nop = (instr == 0) ? ((m_nop < 255) ? m_nop + 1 : 255) : 0;
            if (instr == 0 && m_nop == NOPL) begin
                m_halted = 1; m_run = 0; m_done = 1;
            end else if (old == MAXC - 1) begin
                m_to = 1; m_run = 0; m_done = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".load_ready"}, load_ready, !m_run && !m_done);
        check({tag, ".cpu_reset"}, cpu_reset, !m_run);
        check({tag, ".halted"}, halted, m_halted);
        check({tag, ".timed_out"}, timed_out, m_to);
        check({tag, ".load_err"}, load_err, m_err);
        check({tag, ".cycle_count"}, cycle_count, m_cycles);
        check({tag, ".signature"}, signature, m_sig);
    endtask

    // Inputs are already applied; check fetch, advance the model and the clock, check state.
    task automatic tick(input string tag);
        #1;
        if (m_valid) check({tag, ".fetch"}, fetch_instr, m_fetch(fetch_pc));
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1; load_valid = 0; load_last = 0;
        tick("rst");
        reset = 0;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data, input bit last);
        load_valid = 1; load_addr = (WA_W+1)'(addr); load_data = data; load_last = last;
        tick("load");
        load_valid = 0; load_last = 0;
    endtask

    task automatic run_cycle(input logic [31:0] pc, input logic [31:0] alu);
        fetch_pc = pc; alu_result = alu;
        tick("run");
    endtask

    task automatic fetch_expect(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        fetch_pc = pc;
        #1;
        check(tag, fetch_instr, exp);
    endtask

    logic [31:0] prog [6] = '{32'h200A000A, 32'h016A5820, 32'h200A000D,
                              32'h014B6022, 32'hAD4C0000, 32'h8D4D0000};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_load_ready", load_ready, 1);
        check("rst_signature", signature, SEED);

        // Program load with fetches observed during LOAD and an out-of-range word.
        for (int i = 0; i < 5; i++) load_word(i, prog[i], 0);
        fetch_expect("load_fetch_pc0", 0, 32'h200A000A);
        fetch_expect("load_fetch_pc4", 4, 32'h016A5820);
        fetch_expect("load_fetch_pc6", 6, 32'h016A5820);
        load_word(64, 32'hDEADBEEF, 0);
        check("oob_load_err", load_err, 1);
        fetch_expect("oob_store_unchanged", 0, 32'h200A000A);
        check("pre_last_cpu_reset", cpu_reset, 1);
        load_word(5, prog[5], 1);
        check("post_last_cpu_reset", cpu_reset, 0);
        check("post_last_load_ready", load_ready, 0);

        // Program runs through six words then three NOPs; first two ALU results are 10.
        for (int i = 0; i < 9; i++) begin
            run_cycle(32'(4 * i), (i < 2) ? 32'd10 : $urandom);
            if (i == 0) check("sig_first", signature, 32'h0000000A);
            if (i == 1) check("sig_second", signature, 32'h0000001E);
            if (i < 8) check("halt_not_yet", halted, 0);
        end
        check("nop_halted", halted, 1);
        check("nop_cycle_count", cycle_count, 9);
        check("nop_cpu_reset", cpu_reset, 1);
        check("nop_timed_out", timed_out, 0);
        for (int i = 0; i < 3; i++) run_cycle($urandom_range(0, 20) * 4, $urandom);
        check("done_frozen_count", cycle_count, 9);

        // Timeout with a non-NOP fetch held.
        do_reset();
        load_word(0, prog[0], 1);
        for (int i = 0; i < MAXC; i++) run_cycle(0, $urandom);
        check("to_timed_out", timed_out, 1);
        check("to_cycle_count", cycle_count, MAXC);
        check("to_halted", halted, 0);

        // Halt and timeout land on the same edge.
        do_reset();
        load_word(0, prog[0], 1);
        for (int i = 0; i < MAXC - NOPL; i++) run_cycle(0, $urandom);
        for (int i = 0; i < NOPL; i++) run_cycle(200, $urandom);
        check("coll_halted", halted, 1);
        check("coll_timed_out", timed_out, 0);
        check("coll_cycle_count", cycle_count, MAXC);

        // Reset in the middle of a run discards the program.
        do_reset();
        for (int i = 0; i < 6; i++) load_word(i, prog[i], i == 5);
        for (int i = 0; i < 4; i++) run_cycle(32'(4 * i), $urandom);
        reset = 1;
        tick("midrst");
        reset = 0;
        check("midrst_load_ready", load_ready, 1);
        check("midrst_cpu_reset", cpu_reset, 1);
        check("midrst_cycle_count", cycle_count, 0);
        check("midrst_signature", signature, SEED);
        fetch_expect("midrst_fetch0", 0, 32'h0);
        fetch_expect("midrst_fetch4", 4, 32'h0);
        fetch_expect("midrst_fetch20", 20, 32'h0);

        // Randomized load and run sequences.
        for (int iter = 0; iter < 25; iter++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 8);
            for (int w = 0; w < n; w++) begin
                load_valid = ($urandom_range(0, 3) != 0);
                load_addr  = ($urandom_range(0, 9) == 0) ? (WA_W+1)'($urandom_range(64, 127))
                                                         : (WA_W+1)'($urandom_range(0, 9));
                load_data  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                load_last  = 0;
                tick("rload");
            end
            load_word($urandom_range(0, 9), $urandom, 1);
            for (int c = 0; c < 24; c++) begin
                fetch_pc   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(250, 400))
                                                         : 32'($urandom_range(0, 48));
                alu_result = $urandom;
                load_valid = $urandom_range(0, 1);
                load_addr  = (WA_W+1)'($urandom_range(0, 9));
                load_data  = $urandom;
                reset      = ($urandom_range(0, 60) == 0);
                tick("rrun");
                reset = 0;
                load_valid = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
